// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise divide ops are ignored.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_by_zero
);
  localparam int unsigned   CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q;
  logic               neg_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic               a_neg, b_neg, accept;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod;
`ifdef MULDIV_DIV_EN
  logic               rem_neg_q, dbz_q;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH-1:0]   quo, rem;
`endif

  always_comb begin
    a_neg = ~op[0] & operand_a[WIDTH-1];
    b_neg = ~op[0] & operand_b[WIDTH-1];
    a_mag = a_neg ? -operand_a : operand_a;
    b_mag = b_neg ? -operand_b : operand_b;
`ifdef MULDIV_DIV_EN
    accept = (state_q == IDLE) & start & ~flush;
`else
    accept = (state_q == IDLE) & start & ~flush & ~op[1];
`endif
    // acc_q holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opb_q};
    if (state_q == DIV) begin
      if (!div_trial[WIDTH]) acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                   acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
    end
    quo = neg_q     ? -acc_d[WIDTH-1:0]       : acc_d[WIDTH-1:0];
    rem = rem_neg_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];
`endif
    prod  = neg_q ? -acc_d : acc_d;
    stall = ~rst & (accept | (state_q == MUL) | (state_q == DIV));
    busy  = (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
      rem_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      dbz_q  <= 1'b0;
`endif
      unique case (state_q)
        IDLE: if (accept) begin
          cnt_q <= '0;
          neg_q <= a_neg ^ b_neg;
          opb_q <= b_mag;
          acc_q <= {{WIDTH{1'b0}}, a_mag};
          if (!op[1]) state_q <= MUL;
`ifdef MULDIV_DIV_EN
          else if (operand_b == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            dbz_q   <= 1'b1;
            hi_q    <= operand_a;
            lo_q    <= '1;
          end else begin
            state_q   <= DIV;
            rem_neg_q <= a_neg;
          end
`endif
        end
        MUL: if (flush) state_q <= IDLE;
        else begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            hi_q    <= prod[2*WIDTH-1:WIDTH];
            lo_q    <= prod[WIDTH-1:0];
          end
        end
`ifdef MULDIV_DIV_EN
        DIV: if (flush) state_q <= IDLE;
        else begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            hi_q    <= rem;
            lo_q    <= quo;
          end
        end
`endif
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done   = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;
`ifdef MULDIV_DIV_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit (WIDTH=32); divide vectors run only with MULDIV_DIV_EN.
module tb_ex_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        flush;
  logic        stall, busy, done, div_by_zero;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
    int          lat;
  } vec_t;
  vec_t vecs[$];

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .stall(stall), .busy(busy), .done(done),
    .hi_out(hi_out), .lo_out(lo_out), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] hi, input logic [31:0] lo, input logic dbz, input int lat);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.dbz = dbz; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Drive start in cycle 0 and confirm stall goes high combinationally.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    #1 chk({tag, "_stall_c0"}, stall, 1);
  endtask

  // Returns the cycle in which done is seen (bounded) and how many earlier cycles had stall low.
  task automatic wait_done(output int cyc, output int stall_low);
    cyc = 0; stall_low = 0;
    forever begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (done === 1'b1 || cyc >= 200) break;
      if (stall !== 1'b1) stall_low++;
    end
  endtask

  int cyc, sl, seen;
  logic [31:0] last_hi, last_lo;

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0; flush = 1'b0;

    add(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
    add(2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33);
    add(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33);
    add(2'b01, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0, 33);
    add(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33);
    add(2'b01, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 1'b0, 33);
    add(2'b00, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33);
    add(2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 33);
`ifdef MULDIV_DIV_EN
    add(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
    add(2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1, 1);
    add(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33);
    add(2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 33);
    add(2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33);
    add(2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 33);
    add(2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1);
`endif

    // Reset values while rst is held.
    repeat (2) @(negedge clk);
    start = 1'b1;
    #1;
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_dbz", div_by_zero, 0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("v%0d", i));
      wait_done(cyc, sl);
      chk($sformatf("v%0d_latency", i), cyc, vecs[i].lat);
      chk($sformatf("v%0d_stall_low", i), sl, 0);
      chk($sformatf("v%0d_hi", i), hi_out, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), lo_out, vecs[i].lo);
      chk($sformatf("v%0d_dbz", i), div_by_zero, vecs[i].dbz);
      chk($sformatf("v%0d_stall_done", i), stall, 0);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), done, 0);
      chk($sformatf("v%0d_idle", i), busy, 0);
    end
    last_hi = vecs[vecs.size()-1].hi;
    last_lo = vecs[vecs.size()-1].lo;

    // Flush in cycle 10 aborts the multiply; HI/LO keep previous result.
    issue(2'b00, 32'h00000005, 32'h00000006, "flush");
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("flush_busy_c10", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle_c11", busy, 0);
    chk("flush_stall_c11", stall, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chk("flush_no_done", seen, 0);
    chk("flush_hi_kept", hi_out, last_hi);
    chk("flush_lo_kept", lo_out, last_lo);

    // Asynchronous reset in cycle 5 of a multiply.
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, "rstmid");
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("rstmid_hi", hi_out, 0);
    chk("rstmid_lo", lo_out, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_stall", stall, 0);
    chk("rstmid_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    // flush together with start in IDLE: nothing launches.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b00; operand_a = 32'd3; operand_b = 32'd4;
    #1 chk("fs_stall", stall, 0);
    @(negedge clk);
    chk("fs_busy", busy, 0);
    start = 1'b0; flush = 1'b0;

    // start held during DONE is not accepted there.
    issue(2'b01, 32'h00000003, 32'h00000005, "dn");
    wait_done(cyc, sl);
    chk("dn_latency", cyc, 33);
    chk("dn_lo", lo_out, 32'h0000000F);
    chk("dn_hi", hi_out, 32'h00000000);
    start = 1'b1; op = 2'b01;
    #1 chk("dn_stall_in_done", stall, 0);
    @(negedge clk);
    chk("dn_back_idle", busy, 0);
    start = 1'b0;
    @(negedge clk);
    chk("dn_still_idle", busy, 0);

`ifndef MULDIV_DIV_EN
    // Divide requests are ignored when the divider is not built.
    @(negedge clk);
    start = 1'b1; op = 2'b10; operand_a = 32'd8; operand_b = 32'd2;
    #1 chk("nodiv_stall", stall, 0);
    @(negedge clk);
    chk("nodiv_busy", busy, 0);
    chk("nodiv_stall_held", stall, 0);
    start = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || stall === 1'b1) seen++;
    end
    chk("nodiv_no_activity", seen, 0);
    chk("nodiv_hi", hi_out, 32'h00000000);
    chk("nodiv_lo", lo_out, 32'h0000000F);
    chk("nodiv_dbz", div_by_zero, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-002 Parameter: WIDTH, default 32, operand/HI/LO width.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: start  input  1  mul/div instruction present in EX (from ID/EX control).
REQ-006 Port: op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 Port: operand_a  input  WIDTH  forwarded rs value (multiplicand/dividend).
REQ-008 Port: operand_b  input  WIDTH  forwarded rt value (multiplier/divisor).
REQ-009 Port: flush  input  1  synchronous abort of the in-flight operation.
REQ-010 Port: stall  output  1  freezes PC, IF/ID and ID/EX while high.
REQ-011 Port: busy  output  1  state is not IDLE.
REQ-012 Port: done  output  1  one-cycle pulse; HI/LO valid this cycle.
REQ-013 Port: hi_out  output  WIDTH  HI register (product upper half / remainder).
REQ-014 Port: lo_out  output  WIDTH  LO register (product lower half / quotient).
REQ-015 Port: div_by_zero  output  1  pulses with done when the divisor was zero.

Function
REQ-016 FSM states SHALL be IDLE, MUL, DIV, DONE.
REQ-017 IDLE: start=1 with flush=0 SHALL latch operand magnitudes (signed ops), the result sign, and op; clear the iteration counter; enter MUL (op[1]=0) or DIV (op[1]=1).
REQ-018 MUL SHALL perform one shift-add step per cycle for exactly WIDTH cycles on a 2*WIDTH accumulator, then enter DONE.
REQ-019 DIV SHALL perform one restoring shift-subtract step per cycle for exactly WIDTH cycles, then enter DONE.
REQ-020 DIV with operand_b==0 at start SHALL enter DONE on the next cycle without iterating.
REQ-021 Latency: start sampled at edge 0 -> done high in cycle WIDTH+1 (cycle 1 for divide-by-zero).
REQ-022 On entry to DONE: hi_out/lo_out SHALL update; signed results negated when the sign bit is set; remainder takes the dividend's sign.
REQ-023 Divide-by-zero SHALL give lo_out=all ones, hi_out=dividend, div_by_zero=1.
REQ-024 Signed overflow (most-negative / -1) SHALL give lo_out=most-negative, hi_out=0.
REQ-025 DONE SHALL last one cycle, ignore start, and return to IDLE.
REQ-026 stall SHALL be combinational: high when (IDLE and start and not flush) or state is MUL/DIV; low in DONE.
REQ-027 flush in MUL/DIV SHALL return to IDLE on the next edge; HI/LO unchanged; no done pulse.
REQ-028 flush and start together in IDLE SHALL leave the block in IDLE (flush wins).
REQ-029 hi_out/lo_out SHALL hold their values between operations.

Reset
REQ-030 rst SHALL immediately force state IDLE, counter 0, hi_out=0, lo_out=0, done=0, div_by_zero=0, busy=0, stall=0, regardless of the operation in progress.

Configuration
REQ-031 Macro MULDIV_DIV_EN defined: the divider and the DIV state SHALL be built as specified.
REQ-032 Macro MULDIV_DIV_EN undefined: start with op[1]=1 SHALL be ignored (no stall, no done, HI/LO unchanged), and div_by_zero SHALL be tied to 0.

Verification (WIDTH=32)
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> stall cycles 0-32, done in cycle 33, HI=0xFFFFFFFE, LO=0x00000001.
REQ-034 MULT 0xFFFFFFFD x 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB in cycle 33.
REQ-035 DIV 0xFFFFFFF9 / 0x00000002 (MULDIV_DIV_EN defined) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF in cycle 33.
REQ-036 DIVU 0x64 / 0 -> done and div_by_zero in cycle 1, LO=0xFFFFFFFF, HI=0x00000064.
REQ-037 MULT started, flush in cycle 10 -> IDLE in cycle 11, no done, HI/LO keep prior values; second run with rst in cycle 5 -> all outputs 0 immediately.
REQ-038 MULDIV_DIV_EN undefined, DIV 8/2 start -> stall never high, done never pulses, HI/LO unchanged.
